adder_selftest_driver: RTL and testbench

- Sequential stimulus/checker engine on the operand side of the 32-bit carry-lookahead adder interface.
- Drives A/B/Cin into the adder and samples S/Cout/overFlow after a fixed settle time.
- Checks every sample against an internal behavioural sum and reports pass/fail, error count and first failing vector index.
- Used as on-chip BIST for the adder family, and as the reusable driver for any adder with the same port set.

---
 rtl/adder_selftest_driver.sv | 178 +++++++++++++++++
 tb/tb_adder_selftest_driver.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/adder_selftest_driver.sv
// Self-test driver for 32-bit adders. It drives eight corner vectors and then NUM_RANDOM
// LFSR vectors, and checks S/Cout/overFlow against a behavioural 33-bit sum.
module adder_selftest_driver #(
  parameter int unsigned NUM_RANDOM    = 256,
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter logic [31:0] SEED          = 32'hACE12468
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic [31:0] A,
  output logic [31:0] B,
  output logic        Cin,
  input  logic [31:0] S,
  input  logic        Cout,
  input  logic        overFlow,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [15:0] err_count,
  output logic        fail_valid,
  output logic [15:0] fail_index
);

  localparam logic [31:0] SEED_EFF    = (SEED == 32'd0) ? 32'd1 : SEED;
  localparam logic [31:0] LAST_IDX    = 32'(8 + NUM_RANDOM - 1);
  localparam logic [3:0]  SETTLE_LAST = 4'(SETTLE_CYCLES - 1);
  localparam logic [31:0] TAPS        = 32'h80200003;

  typedef enum logic [2:0] {ST_IDLE, ST_DRIVE, ST_WAIT, ST_CHECK, ST_DONE} state_e;

  state_e      state_q, state_d;
  logic [31:0] idx_q, idx_d;
  logic [3:0]  wait_q, wait_d;
  logic [31:0] lfsr_q, lfsr_d;
  logic [31:0] a_q, a_d, b_q, b_d;
  logic        cin_q, cin_d;
  logic [15:0] err_q, err_d;
  logic        fv_q, fv_d;
  logic [15:0] fi_q, fi_d;
  logic        pass_q, pass_d;

  logic [31:0] exp_s;
  logic        exp_c, exp_v, mismatch;

  function automatic logic [31:0] lfsr_step(input logic [31:0] l);
    return (l >> 1) ^ (l[0] ? TAPS : 32'd0);
  endfunction

  // {A, B} for the fixed corner vectors; carry-in is always 0 for these.
  function automatic logic [63:0] corner_vec(input logic [2:0] i);
    case (i)
      3'd0:    corner_vec = {32'h7FFFFFFF, 32'h00000001};
      3'd1:    corner_vec = {32'h80000000, 32'hFFFFFFFF};
      3'd2:    corner_vec = {32'h0000000A, 32'hFFFFFFFB};
      3'd3:    corner_vec = {32'h00000005, 32'h00000005};
      3'd4:    corner_vec = {32'hFFFFFFFB, 32'hFFFFFFFB};
      3'd5:    corner_vec = {32'h7FFFFFFF, 32'h00000005};
      3'd6:    corner_vec = {32'h80000000, 32'hFFFFFFFB};
      default: corner_vec = {32'h00000005, 32'hFFFFFFFB};
    endcase
  endfunction

  assign {exp_c, exp_s} = {1'b0, a_q} + {1'b0, b_q} + 33'(cin_q);
  assign exp_v = (a_q[31] == b_q[31]) && (exp_s[31] != a_q[31]);

  // An X or Z on the adder outputs leaves the if-condition unknown, so mismatch keeps its 1.
  always_comb begin
    mismatch = 1'b1;
    if ((S == exp_s) && (Cout == exp_c) && (overFlow == exp_v)) mismatch = 1'b0;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_DONE: if (start) state_d = ST_DRIVE;
      ST_DRIVE:         state_d = ST_WAIT;
      ST_WAIT:          if (wait_q == SETTLE_LAST) state_d = ST_CHECK;
      ST_CHECK:         state_d = (idx_q == LAST_IDX) ? ST_DONE : ST_DRIVE;
      default:          state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    // NOTE: every variable gets a default first so no path through the case infers a latch.
    idx_d  = idx_q;
    wait_d = wait_q;
    lfsr_d = lfsr_q;
    a_d    = a_q;
    b_d    = b_q;
    cin_d  = cin_q;
    err_d  = err_q;
    fv_d   = fv_q;
    fi_d   = fi_q;
    pass_d = pass_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          idx_d  = 32'd0;
          wait_d = 4'd0;
          lfsr_d = SEED_EFF;
          err_d  = 16'd0;
          fv_d   = 1'b0;
          fi_d   = 16'd0;
          pass_d = 1'b0;
        end
      end
      ST_DRIVE: begin
        wait_d = 4'd0;
        if (idx_q < 32'd8) begin
          {a_d, b_d} = corner_vec(idx_q[2:0]);
          cin_d      = 1'b0;
        end else begin
          lfsr_d = lfsr_step(lfsr_q);
          a_d    = lfsr_d;
          b_d    = {lfsr_d[15:0], lfsr_d[31:16]};
          cin_d  = lfsr_d[31] ^ lfsr_d[0];
        end
      end
      ST_WAIT: wait_d = wait_q + 4'd1;
      ST_CHECK: begin
        if (mismatch) begin
          if (err_q != 16'hFFFF) err_d = err_q + 16'd1;
          if (!fv_q) begin
            fv_d = 1'b1;
            fi_d = idx_q[15:0];
          end
        end
        if (idx_q == LAST_IDX) pass_d = (err_d == 16'd0);
        else                   idx_d  = idx_q + 32'd1;
      end
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= 32'd0;
      wait_q  <= 4'd0;
      lfsr_q  <= SEED_EFF;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
      cin_q   <= 1'b0;
      err_q   <= 16'd0;
      fv_q    <= 1'b0;
      fi_q    <= 16'd0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      wait_q  <= wait_d;
      lfsr_q  <= lfsr_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cin_q   <= cin_d;
      err_q   <= err_d;
      fv_q    <= fv_d;
      fi_q    <= fi_d;
      pass_q  <= pass_d;
    end
  end

  always_comb begin
    busy = (state_q == ST_DRIVE) || (state_q == ST_WAIT) || (state_q == ST_CHECK);
    done = (state_q == ST_DONE);
  end

  assign A          = a_q;
  assign B          = b_q;
  assign Cin        = cin_q;
  assign pass       = pass_q;
  assign err_count  = err_q;
  assign fail_valid = fv_q;
  assign fail_index = fi_q;

endmodule

// File: tb/tb_adder_selftest_driver.sv
// Directed bench for adder_selftest_driver: a long default-parameter run on a correct adder,
// and a corners-only instance (SETTLE_CYCLES=1) paired with an adder that can carry faults.
module tb_adder_selftest_driver;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Large instance: default parameters, correct adder.
  logic        big_start, big_cin, big_cout, big_v, big_busy, big_done, big_pass, big_fv;
  logic [31:0] big_a, big_b, big_s;
  logic [15:0] big_err, big_fi;

  always_comb begin
    {big_cout, big_s} = {1'b0, big_a} + {1'b0, big_b} + 33'(big_cin);
    big_v = (big_a[31] == big_b[31]) && (big_s[31] != big_a[31]);
  end

  adder_selftest_driver u_big (
    .clk(clk), .rst_n(rst_n), .start(big_start),
    .A(big_a), .B(big_b), .Cin(big_cin),
    .S(big_s), .Cout(big_cout), .overFlow(big_v),
    .busy(big_busy), .done(big_done), .pass(big_pass),
    .err_count(big_err), .fail_valid(big_fv), .fail_index(big_fi)
  );

  // Small instance: corners only. Fault modes: 0 none, 1 overFlow stuck 0, 2 S[15] inverted,
  // 3 Cout stuck 0.
  int          sm_fault;
  logic        sm_start, sm_cin, sm_cout, sm_v, sm_busy, sm_done, sm_pass, sm_fv;
  logic [31:0] sm_a, sm_b, sm_s;
  logic [32:0] sm_sum;
  logic [15:0] sm_err, sm_fi;

  always_comb begin
    sm_sum  = {1'b0, sm_a} + {1'b0, sm_b} + 33'(sm_cin);
    sm_s    = sm_sum[31:0];
    sm_cout = sm_sum[32];
    sm_v    = (sm_a[31] == sm_b[31]) && (sm_sum[31] != sm_a[31]);
    case (sm_fault)
      1:       sm_v     = 1'b0;
      2:       sm_s[15] = ~sm_sum[15];
      3:       sm_cout  = 1'b0;
      default: ;
    endcase
  end

  adder_selftest_driver #(.NUM_RANDOM(0), .SETTLE_CYCLES(1)) u_small (
    .clk(clk), .rst_n(rst_n), .start(sm_start),
    .A(sm_a), .B(sm_b), .Cin(sm_cin),
    .S(sm_s), .Cout(sm_cout), .overFlow(sm_v),
    .busy(sm_busy), .done(sm_done), .pass(sm_pass),
    .err_count(sm_err), .fail_valid(sm_fv), .fail_index(sm_fi)
  );

  logic [31:0] corner_a [8] = '{32'h7FFFFFFF, 32'h80000000, 32'h0000000A, 32'h00000005,
                                32'hFFFFFFFB, 32'h7FFFFFFF, 32'h80000000, 32'h00000005};
  logic [31:0] corner_b [8] = '{32'h00000001, 32'hFFFFFFFF, 32'hFFFFFFFB, 32'h00000005,
                                32'hFFFFFFFB, 32'h00000005, 32'hFFFFFFFB, 32'hFFFFFFFB};

  function automatic logic [31:0] step(input logic [31:0] l);
    return (l >> 1) ^ (l[0] ? 32'h80200003 : 32'd0);
  endfunction

  // Pulses start on the small instance, checks the cleared state one edge later and the
  // corner operands as each vector is driven, and returns edges until done (bounded).
  task automatic run_small(input int fault, output int cyc);
    sm_fault = fault;
    @(negedge clk) sm_start = 1'b1;
    @(posedge clk);
    #1 sm_start = 1'b0;
    cyc = 0;
    check("sm_restart_done", 32'(sm_done), 32'd0);
    check("sm_restart_busy", 32'(sm_busy), 32'd1);
    check("sm_restart_err", 32'(sm_err), 32'd0);
    check("sm_restart_fv", 32'(sm_fv), 32'd0);
    while (!sm_done && cyc < 100) begin
      @(posedge clk);
      #1 cyc++;
      if (cyc % 3 == 1 && cyc <= 22) begin
        check("sm_corner_a", sm_a, corner_a[(cyc - 1) / 3]);
        check("sm_corner_b", sm_b, corner_b[(cyc - 1) / 3]);
      end
    end
  endtask

  initial begin
    int          cyc;
    logic [31:0] l;

    rst_n = 1'b0; big_start = 1'b0; sm_start = 1'b0; sm_fault = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_big_a", big_a, 32'd0);
    check("rst_big_busy", 32'(big_busy), 32'd0);
    check("rst_big_done", 32'(big_done), 32'd0);
    check("rst_big_err", 32'(big_err), 32'd0);
    check("rst_sm_b", sm_b, 32'd0);
    check("rst_sm_pass", 32'(sm_pass), 32'd0);
    @(negedge clk) rst_n = 1'b1;

    // Long run on a correct adder: latency, LFSR vectors 8..23, start ignored while busy.
    l = 32'hACE12468;
    @(negedge clk) big_start = 1'b1;
    @(posedge clk);
    #1 big_start = 1'b0;
    cyc = 0;
    while (!big_done && cyc < 1200) begin
      @(posedge clk);
      #1 cyc++;
      if (cyc == 1) begin
        check("big_v0_a", big_a, 32'h7FFFFFFF);
        check("big_v0_busy", 32'(big_busy), 32'd1);
      end
      if (cyc >= 33 && cyc <= 93 && (cyc - 1) % 4 == 0) begin
        l = step(l);
        check("big_lfsr_a", big_a, l);
        check("big_lfsr_b", big_b, {l[15:0], l[31:16]});
        check("big_lfsr_cin", 32'(big_cin), 32'(l[31] ^ l[0]));
      end
      if (cyc == 50) big_start = 1'b1;
      if (cyc == 53) big_start = 1'b0;
    end
    check("big_done_latency", 32'(cyc), 32'd1056);
    check("big_pass", 32'(big_pass), 32'd1);
    check("big_err", 32'(big_err), 32'd0);
    check("big_fv", 32'(big_fv), 32'd0);
    check("big_fi", 32'(big_fi), 32'd0);
    check("big_busy_done", 32'(big_busy), 32'd0);

    // overFlow stuck at 0: vectors 0,1,5,6 fail.
    run_small(1, cyc);
    check("ovf_latency", 32'(cyc), 32'd24);
    check("ovf_err", 32'(sm_err), 32'd4);
    check("ovf_fv", 32'(sm_fv), 32'd1);
    check("ovf_fi", 32'(sm_fi), 32'd0);
    check("ovf_pass", 32'(sm_pass), 32'd0);

    // S[15] inverted: every vector fails.
    run_small(2, cyc);
    check("s15_err", 32'(sm_err), 32'd8);
    check("s15_fi", 32'(sm_fi), 32'd0);
    check("s15_pass", 32'(sm_pass), 32'd0);

    // Cout stuck at 0: vectors 1,2,4,6,7 carry out.
    run_small(3, cyc);
    check("cout_err", 32'(sm_err), 32'd5);
    check("cout_fv", 32'(sm_fv), 32'd1);
    check("cout_fi", 32'(sm_fi), 32'd1);
    check("cout_a_held", sm_a, 32'h00000005);

    // Restart from DONE after a failing run, now on a correct adder.
    run_small(0, cyc);
    check("clean_latency", 32'(cyc), 32'd24);
    check("clean_err", 32'(sm_err), 32'd0);
    check("clean_pass", 32'(sm_pass), 32'd1);

    // Asynchronous reset during the WAIT of vector 5.
    sm_fault = 1;
    @(negedge clk) sm_start = 1'b1;
    @(posedge clk);
    #1 sm_start = 1'b0;
    repeat (16) @(posedge clk);
    #1;
    check("mid_a_v5", sm_a, 32'h7FFFFFFF);
    check("mid_err", 32'(sm_err), 32'd2);
    check("mid_fv", 32'(sm_fv), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_a", sm_a, 32'd0);
    check("arst_b", sm_b, 32'd0);
    check("arst_cin", 32'(sm_cin), 32'd0);
    check("arst_busy", 32'(sm_busy), 32'd0);
    check("arst_done", 32'(sm_done), 32'd0);
    check("arst_err", 32'(sm_err), 32'd0);
    check("arst_fv", 32'(sm_fv), 32'd0);
    check("arst_fi", 32'(sm_fi), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    run_small(0, cyc);
    check("post_rst_latency", 32'(cyc), 32'd24);
    check("post_rst_err", 32'(sm_err), 32'd0);
    check("post_rst_pass", 32'(sm_pass), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
